// File: rtl/pkt_chk_pkg.sv
// Shared types and constants for the packet framing checker.
// Optional statistics counters are enabled with PKT_CHK_STATS_EN.
package pkt_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    CLOSE  = 2'd2,
    DROP   = 2'd3
  } pkt_chk_state_e;

  localparam int STAT_W = 32;

  // Width of a counter that must hold values 0..max_beats.
  function automatic int len_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/pkt_frame_checker.sv
// Framing checker/repair stage: forwards well-formed packets, drops orphans, closes bad ones.
// Define PKT_CHK_STATS_EN to add the saturating ok/err/drop statistics counters.
module pkt_frame_checker
  import pkt_chk_pkg::*;
#(
  parameter int DATA_W    = 20,
  parameter int MAX_BEATS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_err,
  output logic [1:0]        dbg_state
`ifdef PKT_CHK_STATS_EN
  ,
  output logic [STAT_W-1:0] cnt_pkt_ok,
  output logic [STAT_W-1:0] cnt_pkt_err,
  output logic [STAT_W-1:0] cnt_drop_beats
`endif
);

  localparam int              LEN_W    = len_width(MAX_BEATS);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_BEATS - 1);

  // Handshake: a beat transfers on a rising edge where valid && ready are both high;
  // a producer holds valid and its payload stable until that edge.

  pkt_chk_state_e   state, nxt_state;
  logic [LEN_W-1:0] len, nxt_len;
  logic             load;
  logic             fwd;
  logic             abort;
  logic             drop_beat;
  logic             beat_eop;
  logic             beat_err;

  assign dbg_state = state;

  always_comb begin
    load      = !out_valid || out_ready;
    in_ready  = 1'b0;
    fwd       = 1'b0;
    abort     = 1'b0;
    drop_beat = 1'b0;
    beat_eop  = in_eop;
    beat_err  = 1'b0;
    nxt_state = state;
    nxt_len   = len;
    case (state)
      IDLE: begin
        in_ready = load;
        if (in_valid && load) begin
          if (in_sop) begin
            fwd = 1'b1;
            if (!in_eop) begin
              nxt_state = IN_PKT;
              nxt_len   = LEN_W'(1);
            end
          end else begin
            drop_beat = 1'b1;
          end
        end
      end
      IN_PKT: begin
        in_ready = load && !(in_valid && in_sop);
        if (in_valid && in_sop) begin
          // Abort beat goes out in the same slot when possible, so an abort costs
          // one input bubble; CLOSE only covers a stalled output register.
          if (load) begin
            abort     = 1'b1;
            nxt_state = IDLE;
            nxt_len   = '0;
          end else begin
            nxt_state = CLOSE;
          end
        end else if (in_valid && load) begin
          fwd = 1'b1;
          if (in_eop) begin
            nxt_state = IDLE;
            nxt_len   = '0;
          end else if (len == LEN_LAST) begin
            beat_eop  = 1'b1;
            beat_err  = 1'b1;
            nxt_state = DROP;
            nxt_len   = '0;
          end else begin
            nxt_len = len + LEN_W'(1);
          end
        end
      end
      CLOSE: begin
        if (load) begin
          abort     = 1'b1;
          nxt_state = IDLE;
          nxt_len   = '0;
        end
      end
      DROP: begin
        in_ready = load && !(in_valid && in_sop);
        if (in_valid && in_sop) begin
          nxt_state = IDLE;
        end else if (in_valid && load) begin
          drop_beat = 1'b1;
          if (in_eop) nxt_state = IDLE;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_len   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state <= nxt_state;
      len   <= nxt_len;
      if (load) begin
        out_valid <= fwd || abort;
        if (fwd) begin
          out_data <= in_data;
          out_sop  <= in_sop;
          out_eop  <= beat_eop;
          out_err  <= beat_err;
        end else if (abort) begin
          out_data <= '0;
          out_sop  <= 1'b0;
          out_eop  <= 1'b1;
          out_err  <= 1'b1;
        end
      end
    end
  end

`ifdef PKT_CHK_STATS_EN
  logic inc_ok, inc_err;

  assign inc_ok  = load && fwd && beat_eop && !beat_err;
  assign inc_err = load && ((fwd && beat_err) || abort);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_pkt_ok     <= '0;
      cnt_pkt_err    <= '0;
      cnt_drop_beats <= '0;
    end else begin
      if (inc_ok && cnt_pkt_ok != '1) cnt_pkt_ok <= cnt_pkt_ok + 1'b1;
      if (inc_err && cnt_pkt_err != '1) cnt_pkt_err <= cnt_pkt_err + 1'b1;
      if (drop_beat && cnt_drop_beats != '1) cnt_drop_beats <= cnt_drop_beats + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_frame_checker.sv
// Self-checking bench for pkt_frame_checker: directed framing cases plus randomized
// streams compared against a packet-level reference model.
`timescale 1ns/1ps
module tb_pkt_frame_checker;
  import pkt_chk_pkg::*;

  localparam int DATA_W    = 20;
  localparam int MAX_BEATS = 4;
  localparam int W         = DATA_W + 3;
  localparam int MAX_CYC   = 40000;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_sop = 1'b0;
  logic              in_eop = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic              out_err;
  logic [1:0]        dbg_state;
`ifdef PKT_CHK_STATS_EN
  logic [STAT_W-1:0] cnt_pkt_ok, cnt_pkt_err, cnt_drop_beats;
`endif

  pkt_frame_checker #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err),
    .dbg_state(dbg_state)
`ifdef PKT_CHK_STATS_EN
    , .cnt_pkt_ok(cnt_pkt_ok), .cnt_pkt_err(cnt_pkt_err), .cnt_drop_beats(cnt_drop_beats)
`endif
  );

  // ---------------- scoreboard ----------------
  beat_t          stim_q[$];
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   got_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  bit m_in_pkt, m_drop;
  int m_len, m_ok, m_bad, m_dropped;

  function automatic logic [W-1:0] pack(input bit sop, input bit eop, input bit err,
                                        input logic [DATA_W-1:0] d);
    return {sop, eop, err, d};
  endfunction

  task automatic model_clear();
    m_in_pkt = 0; m_drop = 0; m_len = 0; m_ok = 0; m_bad = 0; m_dropped = 0;
  endtask

  task automatic model_beat(input beat_t b);
    if (m_drop) begin
      if (b.sop) m_drop = 0;
      else begin
        m_dropped++;
        if (b.eop) m_drop = 0;
        return;
      end
    end
    if (m_in_pkt && b.sop) begin
      exp_q.push_back(pack(0, 1, 1, '0));
      m_bad++;
      m_in_pkt = 0;
    end
    if (!m_in_pkt) begin
      if (!b.sop) begin
        m_dropped++;
        return;
      end
      exp_q.push_back(pack(1, b.eop, 0, b.data));
      if (b.eop) m_ok++;
      else begin
        m_in_pkt = 1;
        m_len = 1;
      end
      return;
    end
    m_len++;
    if (b.eop) begin
      exp_q.push_back(pack(0, 1, 0, b.data));
      m_ok++;
      m_in_pkt = 0;
    end else if (m_len == MAX_BEATS) begin
      exp_q.push_back(pack(0, 1, 1, b.data));
      m_bad++;
      m_in_pkt = 0;
      m_drop = 1;
    end else begin
      exp_q.push_back(pack(0, 0, 0, b.data));
    end
  endtask

  task automatic add(input bit sop, input bit eop, input logic [DATA_W-1:0] d);
    beat_t b;
    b.sop = sop; b.eop = eop; b.data = d;
    stim_q.push_back(b);
    model_beat(b);
  endtask

  // ---------------- driver / monitor ----------------
  int  valid_pct = 100;
  int  ready_pct = 100;
  int  bubbles   = 0;
  bit  chk_lat   = 0;
  bit  lat_pend  = 0;
  bit  fired     = 0;
  bit  hold_pend = 0;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W+3:0] hold_snap;

  task automatic step();
    @(negedge clk);
    if (hold_pend)
      check("hold_stable", {out_valid, out_sop, out_eop, out_err, out_data}, hold_snap);
    if (lat_pend)
      check("latency", {out_valid, out_data}, {1'b1, lat_data});
    if (fired) begin
      in_valid = 1'b0;
      fired = 0;
    end
    if (!in_valid && stim_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      in_valid = 1'b1;
      {in_sop, in_eop, in_data} = stim_q[0];
    end
    out_ready = ($urandom_range(99) < ready_pct);
    #1;
    hold_pend = out_valid && !out_ready;
    hold_snap = {out_valid, out_sop, out_eop, out_err, out_data};
    if (out_valid && out_ready) got_q.push_back({out_sop, out_eop, out_err, out_data});
    if (in_valid && !in_ready) bubbles++;
    lat_pend = chk_lat && in_valid && in_ready;
    lat_data = in_data;
    if (in_valid && in_ready) begin
      void'(stim_q.pop_front());
      fired = 1;
    end
  endtask

  task automatic run(input string name, input int vp, input int rp);
    int cyc = 0;
    valid_pct = vp;
    ready_pct = rp;
    while ((stim_q.size() > 0 || in_valid || got_q.size() < exp_q.size()) && cyc < MAX_CYC) begin
      step();
      cyc++;
    end
    lat_pend = 0;
    check({name, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check(name, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    stim_q.delete();
  endtask

  task automatic check_stats(input string name);
`ifdef PKT_CHK_STATS_EN
    check({name, "_cnt_ok"}, cnt_pkt_ok, m_ok);
    check({name, "_cnt_err"}, cnt_pkt_err, m_bad);
    check({name, "_cnt_drop"}, cnt_drop_beats, m_dropped);
`else
    check({name, "_idle_state"}, dbg_state, IDLE);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    fired = 0; hold_pend = 0; lat_pend = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    stim_q.delete(); exp_q.delete(); got_q.delete();
  endtask

  // ---------------- tests ----------------
  initial begin
    logic [DATA_W-1:0] d;
    int len;

    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flags", {out_sop, out_eop, out_err}, 3'b000);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", dbg_state, IDLE);

    // back-to-back 3-beat packets with single-cycle latency
    chk_lat = 1;
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 3; i++) add(i == 0, i == 2, DATA_W'(16 * p + i + 1));
    run("b2b", 100, 100);
    chk_lat = 0;
    check_stats("b2b");

    // orphan beats ahead of a single-beat packet
    add(0, 0, 'hA); add(0, 0, 'hB); add(1, 1, 'hC);
    run("orphan", 100, 100);
    check_stats("orphan");

    // new sop inside a packet: abort then single-beat packet, one input bubble
    bubbles = 0;
    add(1, 0, 'h1); add(0, 0, 'h2); add(1, 1, 'h3);
    run("abort", 100, 100);
    check("abort_bubble", bubbles, 1);
    check_stats("abort");

    // oversize packet truncated at MAX_BEATS, tail dropped
    for (int i = 0; i < 6; i++) add(i == 0, i == 5, DATA_W'('h10 + i));
    run("oversize", 100, 100);
    check_stats("oversize");

    // reset while a beat is held in the output register
    hold_pend = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = 'h5; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("prerst_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_state", dbg_state, IDLE);
    check("midrst_ready", in_ready, 1);
    model_clear();
    add(0, 0, 'h7); add(1, 1, 'h8);
    run("post_rst", 100, 100);
    check_stats("post_rst");

    // 1000 well-formed packets under random backpressure
    do_reset();
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, MAX_BEATS);
      for (int i = 0; i < len; i++) begin
        d = DATA_W'($urandom());
        add(i == 0, i == len - 1, d);
      end
    end
    run("wellformed", 70, 50);
    check("wellformed_pkts", m_ok, 1000);
    check_stats("wellformed");

    // arbitrary sop/eop soup exercising every repair path
    for (int i = 0; i < 400; i++) begin
      d = DATA_W'($urandom());
      add($urandom_range(99) < 30, $urandom_range(99) < 30, d);
    end
    add(1, 1, 'h3FF);
    run("mixed", 80, 60);
    check_stats("mixed");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
